// File: rtl/vc_tx_pkg.sv
// Shared constants and types for the virtual-channel transmitter.
package vc_tx_pkg;

    localparam int FLIT_SIZE        = 32;
    localparam int DEF_FIFO_DEPTH   = 4;
    localparam int DEF_DROP_TIMEOUT = 8;

    typedef logic [FLIT_SIZE-1:0] flit_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_DROP = 2'd2,
        ST_WAIT_RISE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/vc_tx_if.sv
// Flit handshake between the local injector, the transmitter and the
// downstream virtual-channel buffer.
interface vc_tx_if;
    import vc_tx_pkg::*;

    flit_t in_flit;
    logic  in_valid;
    logic  in_ready;
    flit_t flit;
    logic  load;
    logic  down_credit;

    // Environment side: injector plus downstream buffer.
    modport master (
        output in_flit,
        output in_valid,
        input  in_ready,
        input  flit,
        input  load,
        output down_credit
    );

    // Transmitter side.
    modport slave (
        input  in_flit,
        input  in_valid,
        output in_ready,
        output flit,
        output load,
        input  down_credit
    );

endinterface

// File: rtl/vc_tx_fifo.sv
// Small circular flit FIFO; depth must be a power of two so the pointers
// wrap naturally. Head is presented combinationally on rdata.
module tx_fifo
    import vc_tx_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int WIDTH = FLIT_SIZE,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next storage, pointer and occupancy; push+pop together leaves count alone.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/vc_tx.sv
// Virtual-channel transmitter: buffers flits from the local injector and
// forwards them one at a time to a downstream VC buffer, pacing each send
// on a full fall/rise cycle of the downstream credit.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | waiting for a queued flit and credit high; pops on exit
// ST_SEND      | load strobe is high for this single cycle
// ST_WAIT_DROP | waiting for credit to fall (downstream took the flit);
//              | bounded by DROP_TIMEOUT, expiry flags protocol_err
// ST_WAIT_RISE | waiting for credit to return high (downstream drained)
module vc_tx
    import vc_tx_pkg::*;
#(
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int DROP_TIMEOUT = DEF_DROP_TIMEOUT
) (
    input  logic        clock,
    input  logic        reset,
    vc_tx_if.slave      bus,
    output logic        busy,
    output logic        protocol_err,
    output logic [15:0] flits_sent
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = $clog2(DROP_TIMEOUT + 1);

    tx_state_e   state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    flit_t       flit_q, flit_d;
    logic        load_q, load_d;
    logic        protocol_err_q, protocol_err_d;
    logic [15:0] flits_sent_q, flits_sent_d;

    flit_t       fifo_head;
    logic [CW-1:0] fifo_count;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_push;
    logic        fifo_pop;

    // Credit is only honoured as a send permission from IDLE; the credit
    // still reads high for a couple of cycles after a load, which WAIT_DROP
    // deliberately ignores so the same credit window never sends twice.
    assign bus.in_ready = (fifo_count < CW'(FIFO_DEPTH));
    assign fifo_push    = bus.in_valid && !fifo_full;
    assign fifo_pop     = (state_q == ST_IDLE) && !fifo_empty && bus.down_credit;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FLIT_SIZE)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .wdata (bus.in_flit),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state and registered-output logic for the send sequencer.
    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        flit_d         = flit_q;
        load_d         = 1'b0;
        protocol_err_d = protocol_err_q;
        flits_sent_d   = flits_sent_q;
        case (state_q)
            ST_IDLE: begin
                if (fifo_pop) begin
                    state_d      = ST_SEND;
                    flit_d       = fifo_head;
                    load_d       = 1'b1;
                    flits_sent_d = flits_sent_q + 16'd1;
                end
            end
            ST_SEND: begin
                state_d = ST_WAIT_DROP;
                timer_d = TW'(DROP_TIMEOUT);
            end
            ST_WAIT_DROP: begin
                if (!bus.down_credit) begin
                    state_d = ST_WAIT_RISE;
                    timer_d = '0;
                end else if (timer_q == '0) begin
                    state_d        = ST_WAIT_RISE;
                    protocol_err_d = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_WAIT_RISE: begin
                if (bus.down_credit) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            timer_q        <= '0;
            flit_q         <= '0;
            load_q         <= 1'b0;
            protocol_err_q <= 1'b0;
            flits_sent_q   <= 16'd0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            flit_q         <= flit_d;
            load_q         <= load_d;
            protocol_err_q <= protocol_err_d;
            flits_sent_q   <= flits_sent_d;
        end
    end

    assign bus.flit     = flit_q;
    assign bus.load     = load_q;
    assign busy         = (state_q != ST_IDLE) || !fifo_empty;
    assign protocol_err = protocol_err_q;
    assign flits_sent   = flits_sent_q;

endmodule

// File: tb/tb_vc_tx.sv
// Scoreboard bench for vc_tx: stimulus queues expected flits and send
// counts; a monitor pops and compares on every load strobe, and a small
// downstream VC model paces the credit line.
module tb_vc_tx;
    import vc_tx_pkg::*;

    localparam int DT = DEF_DROP_TIMEOUT;

    typedef struct {
        flit_t       flit;
        logic [15:0] sent;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        busy;
    logic        protocol_err;
    logic [15:0] flits_sent;

    logic        model_en     = 1'b0;
    logic        credit_model = 1'b1;
    logic        credit_man   = 1'b0;
    logic        vc_hold      = 1'b0;
    int          vc_tmr       = 0;
    logic        prev_load    = 1'b0;

    exp_t        exp_q[$];
    logic [15:0] sent_model;
    int          n_checks = 0;
    int          n_errors = 0;

    vc_tx_if vif();

    assign vif.down_credit = model_en ? credit_model : credit_man;

    vc_tx #(
        .FIFO_DEPTH   (4),
        .DROP_TIMEOUT (DT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (vif.slave),
        .busy         (busy),
        .protocol_err (protocol_err),
        .flits_sent   (flits_sent)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_push(input flit_t d);
        exp_t e;
        sent_model = sent_model + 16'd1;
        e.flit = d;
        e.sent = sent_model;
        exp_q.push_back(e);
    endtask

    task automatic push(input flit_t d);
        vif.in_flit  = d;
        vif.in_valid = 1'b1;
        @(negedge clock);
        vif.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clock);
            if (!busy && exp_q.size() == 0) done = 1'b1;
        end
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL %s: not idle after %0d cycles, %0d flits outstanding", name, budget, exp_q.size());
        end
    endtask

    task automatic wait_load(input string name, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clock);
            if (vif.load === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL %s: no load within %0d cycles", name, budget);
        end
    endtask

    // Monitor: every load must match the oldest expectation, one cycle wide.
    initial begin
        forever begin
            @(negedge clock);
            if (reset === 1'b1 && vif.load === 1'b1) begin
                exp_t e;
                n_checks++;
                if (prev_load) begin
                    n_errors++;
                    $display("FAIL load_width: load high on two consecutive cycles");
                end
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_load: flit 0x%0h with nothing outstanding", vif.flit);
                end else begin
                    e = exp_q.pop_front();
                    check("load_flit", vif.flit, e.flit);
                    check("load_count", {16'h0, flits_sent}, {16'h0, e.sent});
                end
            end
            prev_load = (reset === 1'b1) && (vif.load === 1'b1);
        end
    end

    // Downstream VC model: credit falls 2 cycles after a load, returns 16 later.
    initial begin
        forever begin
            @(negedge clock);
            if (!model_en) begin
                vc_hold      = 1'b0;
                vc_tmr       = 0;
                credit_model = 1'b1;
            end else if (vif.load === 1'b1) begin
                n_checks++;
                if (vc_hold) begin
                    n_errors++;
                    $display("FAIL credit_window: second load inside one credit cycle");
                end
                vc_hold = 1'b1;
                vc_tmr  = 0;
            end else if (vc_hold) begin
                vc_tmr++;
                if (vc_tmr == 2) begin
                    credit_model = 1'b0;
                end else if (vc_tmr == 18) begin
                    credit_model = 1'b1;
                    vc_hold      = 1'b0;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset        = 1'b0;
        vif.in_valid = 1'b0;
        vif.in_flit  = '0;
        sent_model   = 16'd0;

        // Reset state.
        repeat (3) @(negedge clock);
        check("rst_load", {31'h0, vif.load}, 32'h0);
        check("rst_flit", vif.flit, 32'h0);
        check("rst_sent", {16'h0, flits_sent}, 32'h0);
        check("rst_err", {31'h0, protocol_err}, 32'h0);
        check("rst_ready", {31'h0, vif.in_ready}, 32'h1);
        check("rst_busy", {31'h0, busy}, 32'h0);
        reset = 1'b1;
        @(negedge clock);
        check("rel_ready", {31'h0, vif.in_ready}, 32'h1);
        check("rel_load", {31'h0, vif.load}, 32'h0);

        // Single flit through a full credit cycle.
        model_en = 1'b1;
        exp_push(32'hA5A5_A5A5);
        push(32'hA5A5_A5A5);
        wait_idle("single_idle", 100);
        check("single_sent", {16'h0, flits_sent}, 32'd1);
        check("single_err", {31'h0, protocol_err}, 32'h0);

        // Back-to-back: four flits delivered in order, one per credit cycle.
        exp_push(32'h1111_1111);
        exp_push(32'h2222_2222);
        exp_push(32'h3333_3333);
        exp_push(32'h4444_4444);
        push(32'h1111_1111);
        push(32'h2222_2222);
        push(32'h3333_3333);
        push(32'h4444_4444);
        wait_idle("b2b_idle", 300);
        check("b2b_sent", {16'h0, flits_sent}, 32'd5);

        // Full FIFO: fifth push with no credit is dropped.
        model_en   = 1'b0;
        credit_man = 1'b0;
        for (int k = 0; k < 5; k++) begin
            vif.in_flit  = 32'hB000_0001 + k;
            vif.in_valid = 1'b1;
            check($sformatf("full_ready_%0d", k), {31'h0, vif.in_ready}, (k < 4) ? 32'h1 : 32'h0);
            if (k < 4) exp_push(32'hB000_0001 + k);
            @(negedge clock);
        end
        vif.in_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("full_ready_hold", {31'h0, vif.in_ready}, 32'h0);
        check("full_busy", {31'h0, busy}, 32'h1);
        model_en = 1'b1;
        wait_idle("full_idle", 300);
        check("full_sent", {16'h0, flits_sent}, 32'd9);
        check("full_ready_after", {31'h0, vif.in_ready}, 32'h1);

        // Timeout: credit never falls after a send.
        model_en   = 1'b0;
        credit_man = 1'b1;
        exp_push(32'hC1C1_C1C1);
        push(32'hC1C1_C1C1);
        wait_load("to_load", 20);
        repeat (DT - 1) @(negedge clock);
        check("to_err_early", {31'h0, protocol_err}, 32'h0);
        repeat (4) @(negedge clock);
        check("to_err_set", {31'h0, protocol_err}, 32'h1);
        repeat (5) @(negedge clock);
        check("to_err_sticky", {31'h0, protocol_err}, 32'h1);
        exp_push(32'hC2C2_C2C2);
        push(32'hC2C2_C2C2);
        wait_idle("to_idle", 100);
        check("to_sent", {16'h0, flits_sent}, 32'd11);
        check("to_err_final", {31'h0, protocol_err}, 32'h1);

        // Reset while in WAIT_DROP with three flits queued.
        exp_push(32'hD1D1_D1D1);
        push(32'hD1D1_D1D1);
        wait_load("rm_load", 20);
        push(32'hD2D2_D2D2);
        push(32'hD3D3_D3D3);
        push(32'hD4D4_D4D4);
        check("rm_busy_before", {31'h0, busy}, 32'h1);
        reset = 1'b0;
        exp_q.delete();
        sent_model = 16'd0;
        #1;
        check("rm_load", {31'h0, vif.load}, 32'h0);
        check("rm_sent", {16'h0, flits_sent}, 32'h0);
        check("rm_ready", {31'h0, vif.in_ready}, 32'h1);
        check("rm_busy", {31'h0, busy}, 32'h0);
        check("rm_err", {31'h0, protocol_err}, 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rm_first_load", {31'h0, vif.load}, 32'h0);
        repeat (20) @(negedge clock);
        check("rm_sent_after", {16'h0, flits_sent}, 32'h0);
        check("rm_busy_after", {31'h0, busy}, 32'h0);

        // Counter wrap from a preloaded 0xFFFF.
        model_en = 1'b1;
        force dut.flits_sent_q = 16'hFFFF;
        @(negedge clock);
        release dut.flits_sent_q;
        sent_model = 16'hFFFF;
        @(negedge clock);
        check("wrap_preload", {16'h0, flits_sent}, 32'h0000_FFFF);
        exp_push(32'hE1E1_E1E1);
        exp_push(32'hE2E2_E2E2);
        push(32'hE1E1_E1E1);
        push(32'hE2E2_E2E2);
        wait_idle("wrap_idle", 200);
        check("wrap_sent", {16'h0, flits_sent}, 32'h0000_0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
